program_sequencer: RTL
======================

Name: program_sequencer

Overview:
- Successor to the single-counter program counter in the 1-bit processor core.
- Generates the instruction address every cycle. Supports increment, skip-next, absolute jump, subroutine call and return.
- Call/return use an internal LIFO return-address stack. Address width and stack depth are parametrised.
- Sits between the instruction decoder (which drives op/target) and program memory (which consumes pc).

Parameters:
- ADDR_W, 8, width of program address.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, value loaded into pc on reset.
- TRAP_ADDR, all-ones (2**ADDR_W-1), error vector; used only when SEQ_TRAP_EN is defined.

Ports:
- clk  input  1  clock; all state changes on the falling edge, matching the existing core.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; when 0, all state holds.
- op  input  3  sequencer operation (seq_op_e).
- target  input  ADDR_W  destination address for JUMP/CALL.
- clr_err  input  1  clears sticky error flags.
- pc  output  ADDR_W  current program address.
- top  output  ADDR_W  return address at top of stack; 0 when empty.
- level  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky: CALL attempted with stack full.
- underflow  output  1  sticky: RET attempted with stack empty.

Behaviour:
- Reset (rst high, asynchronous, immediate):
  - pc=RESET_ADDR; level=0; top=0; overflow=0; underflow=0; stack contents don't-care.
  - Reset mid-call/return aborts the operation fully; no partial push/pop.
- Update: on each falling clk edge with rst low. If en=0, nothing changes, including clr_err handling. With en=1, by op:
  - INC: pc <= pc+1.
  - SKIP: pc <= pc+2 (skips next instruction).
  - JUMP: pc <= target.
  - CALL, level<STACK_DEPTH: push pc+1, level+1, pc <= target.
  - CALL, level==STACK_DEPTH: no push; overflow <= 1; pc <= target.
  - RET, level>0: pc <= top, pop, level-1.
  - RET, level==0: underflow <= 1; pc <= pc+1.
  - NOP (and undefined encodings): pc and stack hold.
- Arithmetic: all address arithmetic is modulo 2**ADDR_W.
  - pc = all-ones with INC -> 0.
  - SKIP from all-ones -> 1.
  - CALL at all-ones pushes 0.
- Latency:
  - pc reflects the op one falling edge after it is sampled.
  - top and level are registered and update on the same edge as pc.
- Error flags:
  - clr_err=1 (with en=1) clears overflow and underflow on that edge.
  - If a new error occurs on the same edge, the new error flag is set; set wins over clear.
  - Flags are never cleared by a successful op.
- Stack ordering:
  - CALL followed by RET returns to the instruction after the CALL.
  - Nested calls return in LIFO order.

Optional Feature:
- Macro: SEQ_TRAP_EN.
- Defined:
  - Overflowing CALL sets pc <= TRAP_ADDR instead of target.
  - Underflowing RET sets pc <= TRAP_ADDR instead of pc+1.
  - Flags are set as normal; stack is unchanged.
- Undefined: behaviour exactly as in Behaviour; TRAP_ADDR is ignored.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [2:0] seq_op_e: NOP=0, INC=1, SKIP=2, JUMP=3, CALL=4, RET=5.
  - Undefined encodings 6–7 act as NOP.
- Sub-module return_stack (ADDR_W, STACK_DEPTH):
  - Register-array LIFO with push/pop/din, top, level, full, empty.
  - Same clk edge and asynchronous reset.
  - Push when full and pop when empty are ignored internally.
- program_sequencer owns pc, flag logic and op decode.

Test Plan:
- Reset/increment: assert rst mid-run with pc=0x37, level=2 -> pc=0x00, level=0, flags 0 immediately. Then 3x INC -> pc=0x03.
- Wrap and skip: pc=0xFE, INC -> 0xFF; SKIP -> 0x01. Hold en=0 for 4 cycles -> pc stays 0x01.
- Nested call/return: pc=0x10 CALL 0x40; at 0x41 CALL 0x80; RET -> pc=0x42; RET -> pc=0x11; level 0->1->2->1->0.
- Overflow (default depth 4): 5 consecutive CALLs, the fifth to target 0x20 -> level=4, overflow=1, pc=0x20.
  - With SEQ_TRAP_EN: pc=0xFF.
  - Then 4 RETs unwind correctly.
- Underflow and clear: RET at pc=0x05 with level=0 -> underflow=1, pc=0x06 (0xFF with SEQ_TRAP_EN).
  - clr_err with INC -> underflow=0.
  - clr_err with RET on empty stack -> underflow stays 1.
- Parameter sweep: ADDR_W=12, STACK_DEPTH=1. CALL 0xABC from 0xFFF pushes 0x000; second CALL sets overflow; RET -> pc=0x000.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Purpose : shared types for the program sequencer (operation encoding).
// Latency : n/a (types only).
// Backpressure: n/a.
//
// seq_op_e is the operation the instruction decoder hands the sequencer each
// cycle. Encodings 6 and 7 are deliberately left undefined; the sequencer
// treats them exactly like NOP so a corrupted decode cannot move the pc.
package seq_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        INC  = 3'd1,
        SKIP = 3'd2,
        JUMP = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } seq_op_e;

    // Width needed to count 0..depth inclusive (stack level).
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Purpose : decoder <-> sequencer connection bundle.
// Latency : n/a (wires only).
// Backpressure: none; en is the only throttle, held low to freeze the sequencer.
//
// Signals:
//   en        decoder -> seq   advance enable
//   op        decoder -> seq   operation (seq_op_e encoding)
//   target    decoder -> seq   JUMP/CALL destination
//   clr_err   decoder -> seq   clear sticky error flags
//   pc        seq -> memory    current program address
//   top       seq -> decoder   return address at top of stack (0 when empty)
//   level     seq -> decoder   number of valid stack entries
//   overflow  seq -> decoder   sticky: CALL with full stack
//   underflow seq -> decoder   sticky: RET with empty stack
interface program_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LVL_W = level_width(STACK_DEPTH);

    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              clr_err;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] top;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    // Decoder side.
    modport master (
        output en, op, target, clr_err,
        input  pc, top, level, overflow, underflow
    );

    // Sequencer side.
    modport slave (
        input  en, op, target, clr_err,
        output pc, top, level, overflow, underflow
    );

endinterface

// File: rtl/program_sequencer_return_stack.sv
// Purpose : register-array LIFO holding subroutine return addresses.
// Latency : push/pop take effect on the falling edge; o_top/o_level follow immediately after it.
// Backpressure: none; push when full and pop when empty are silently dropped.
//
// Ports:
//   i_clk, i_rst      falling-edge clock, async active-high reset
//   i_push, i_din     write i_din as the new top entry
//   i_pop             discard the top entry
//   o_top             top entry, 0 when empty
//   o_level           number of valid entries
//   o_full, o_empty   level == STACK_DEPTH / level == 0
module return_stack
    import seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W      = level_width(STACK_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_din,
    output logic [ADDR_W-1:0] o_top,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_full,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [ADDR_W-1:0] w_top;

    assign w_full    = (r_level == LVL_W'(STACK_DEPTH));
    assign w_empty   = (r_level == '0);
    // The sequencer never asks for both at once; push is given priority anyway.
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty & ~i_push;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= '0;
        end else if (w_do_push) begin
            r_level <= r_level + LVL_W'(1);
        end else if (w_do_pop) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    // Entry storage needs no reset: anything at or above r_level is invalid,
    // and o_top is forced to 0 when the stack is empty.
    always_ff @(negedge i_clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_do_push && (r_level == LVL_W'(i))) begin
                r_mem[i] <= i_din;
            end
        end
    end

    // Top of stack is entry level-1; a compare per slot avoids indexing the
    // array with a counter that is one bit wider than the array needs.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_level == LVL_W'(i + 1)) begin
                w_top = r_mem[i];
            end
        end
    end

    assign o_top   = w_top;
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/program_sequencer.sv
// Purpose : instruction-address generator with increment/skip/jump/call/return.
// Latency : one falling edge from op sampled to pc/top/level/flags updated.
// Backpressure: none; bus.en low freezes every piece of state, including error clearing.
//
// Ports:
//   clk   falling-edge clock
//   rst   asynchronous active-high reset (pc <= RESET_ADDR, stack emptied, flags cleared)
//   bus   program_sequencer_if.slave: en/op/target/clr_err in, pc/top/level/overflow/underflow out
//
// Build option: define SEQ_TRAP_EN to redirect an overflowing CALL or an
// underflowing RET to TRAP_ADDR. Without it, TRAP_ADDR has no effect.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = '1
) (
    input  logic               clk,
    input  logic               rst,
    program_sequencer_if.slave bus
);

    localparam int LVL_W = level_width(STACK_DEPTH);

`ifdef SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] r_pc;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_plus2;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [ADDR_W-1:0] w_top;
    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;

    // Natural wrap of the ADDR_W-bit adders gives the modulo arithmetic:
    // all-ones +1 -> 0, all-ones +2 -> 1, and a CALL at all-ones pushes 0.
    assign w_pc_plus1 = r_pc + ADDR_W'(1);
    assign w_pc_plus2 = r_pc + ADDR_W'(2);

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc_plus1),
        .o_top   (w_top),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Op decode. Every stack and flag request is gated by en here, so the
    // stack and the pc register always move together.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (bus.en) begin
            case (bus.op)
                INC:  w_pc_nxt = w_pc_plus1;
                SKIP: w_pc_nxt = w_pc_plus2;
                JUMP: w_pc_nxt = bus.target;
                CALL: begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                        w_pc_nxt  = TRAP_EN ? TRAP_ADDR : bus.target;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_nxt  = bus.target;
                    end
                end
                RET: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                        w_pc_nxt  = TRAP_EN ? TRAP_ADDR : w_pc_plus1;
                    end else begin
                        w_pop     = 1'b1;
                        w_pc_nxt  = w_top;
                    end
                end
                default: w_pc_nxt = r_pc;   // NOP and encodings 6/7
            endcase
        end
    end

    // pc and sticky flags. A new error on the same edge as clr_err wins
    // over the clear; successful ops never touch the flags.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= RESET_ADDR;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (bus.en) begin
            r_pc  <= w_pc_nxt;
            r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_err);
            r_unf <= w_unf_set | (r_unf & ~bus.clr_err);
        end
    end

    assign bus.pc        = r_pc;
    assign bus.top       = w_top;
    assign bus.level     = w_level;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

endmodule
